// File: rtl/axis_mash.sv
// rtl/axis_mash.sv - runtime-selectable 1..3 stage MASH delta-sigma modulator with AXI-Stream ports
module axis_mash #(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 4
) (
    input  logic                 aclk,
    input  logic                 arst_n,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     s_axis_data_tdata,
    input  logic                 s_axis_data_tvalid,
    output logic                 s_axis_data_tready,
    output logic [OUT_WIDTH-1:0] m_axis_data_tdata,
    output logic                 m_axis_data_tvalid,
    input  logic                 m_axis_data_tready
);
    // Per-stage accumulators and the carry history used for noise cancellation.
    logic [WIDTH-1:0]     acc1_q, acc1_d;
    logic [WIDTH-1:0]     acc2_q, acc2_d;
    logic [WIDTH-1:0]     acc3_q, acc3_d;
    logic                 c2_d1_q, c2_d1_d;
    logic                 c3_d1_q, c3_d1_d;
    logic                 c3_d2_q, c3_d2_d;
    logic [1:0]           mode_q;
    logic                 run_q;
    logic [OUT_WIDTH-1:0] tdata_q, tdata_d;
    logic                 tvalid_q, tvalid_d;

    logic                 mode_change;
    logic                 accept;
    logic [1:0]           stages;
    logic [WIDTH:0]       s1, s2, s3;
    logic                 c1, c2, c3;
    logic signed [3:0]    y;

    // A mode change restarts the modulator, so no sample may be taken on that edge.
    assign mode_change        = (mode != mode_q);
    assign s_axis_data_tready = run_q && !mode_change && (!tvalid_q || m_axis_data_tready);
    assign accept             = s_axis_data_tvalid && s_axis_data_tready;
    assign stages             = (mode_q == 2'd0) ? 2'd1 : mode_q;

    assign m_axis_data_tdata  = tdata_q;
    assign m_axis_data_tvalid = tvalid_q;

    // Cascaded stage sums: each stage integrates the previous stage's fresh residue.
    always_comb begin
        s1 = {1'b0, acc1_q} + {1'b0, s_axis_data_tdata};
        s2 = {1'b0, acc2_q} + {1'b0, s1[WIDTH-1:0]};
        s3 = {1'b0, acc3_q} + {1'b0, s2[WIDTH-1:0]};
        c1 = s1[WIDTH];
        c2 = (stages >= 2'd2) ? s2[WIDTH] : 1'b0;
        c3 = (stages == 2'd3) ? s3[WIDTH] : 1'b0;
        // Differentiated carries of the later stages cancel the earlier stages' error.
        // Delays of inactive stages stay at zero, so one expression covers every mode.
        y  = 4'(c1) + 4'(c2) - 4'(c2_d1_q) + 4'(c3)
           - {2'b00, c3_d1_q, 1'b0} + 4'(c3_d2_q);
    end

    // Next state: clear on mode change, advance only on an accepted sample.
    always_comb begin
        acc1_d  = acc1_q;
        acc2_d  = acc2_q;
        acc3_d  = acc3_q;
        c2_d1_d = c2_d1_q;
        c3_d1_d = c3_d1_q;
        c3_d2_d = c3_d2_q;
        tdata_d = tdata_q;
        tvalid_d = tvalid_q;
        if (mode_change) begin
            acc1_d  = '0;
            acc2_d  = '0;
            acc3_d  = '0;
            c2_d1_d = 1'b0;
            c3_d1_d = 1'b0;
            c3_d2_d = 1'b0;
        end else if (accept) begin
            acc1_d = s1[WIDTH-1:0];
            if (stages >= 2'd2) begin
                acc2_d  = s2[WIDTH-1:0];
                c2_d1_d = c2;
            end
            if (stages == 2'd3) begin
                acc3_d  = s3[WIDTH-1:0];
                c3_d2_d = c3_d1_q;
                c3_d1_d = c3;
            end
        end
        if (accept) begin
            tdata_d  = OUT_WIDTH'(y);
            tvalid_d = 1'b1;
        end else if (tvalid_q && m_axis_data_tready) begin
            tvalid_d = 1'b0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            acc1_q   <= '0;
            acc2_q   <= '0;
            acc3_q   <= '0;
            c2_d1_q  <= 1'b0;
            c3_d1_q  <= 1'b0;
            c3_d2_q  <= 1'b0;
            mode_q   <= 2'd0;
            run_q    <= 1'b0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
        end else begin
            acc1_q   <= acc1_d;
            acc2_q   <= acc2_d;
            acc3_q   <= acc3_d;
            c2_d1_q  <= c2_d1_d;
            c3_d1_q  <= c3_d1_d;
            c3_d2_q  <= c3_d2_d;
            mode_q   <= mode;
            run_q    <= 1'b1;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
        end
    end
endmodule

// File: tb/tb_axis_mash.sv
// tb/tb_axis_mash.sv - scoreboard and vector-table bench for axis_mash
module tb_axis_mash;
    logic        aclk = 1'b0;
    logic        arst_n;
    logic [1:0]  mode;
    logic [15:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [3:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;

    axis_mash #(.WIDTH(16), .OUT_WIDTH(4)) dut (
        .aclk               (aclk),
        .arst_n             (arst_n),
        .mode               (mode),
        .s_axis_data_tdata  (s_tdata),
        .s_axis_data_tvalid (s_tvalid),
        .s_axis_data_tready (s_tready),
        .m_axis_data_tdata  (m_tdata),
        .m_axis_data_tvalid (m_tvalid),
        .m_axis_data_tready (m_tready)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_pass   = 0;
    int sb[$];
    int outs[$];
    int sum, ymin, ymax, n_out;

    int m_a1, m_a2, m_a3, m_c2p, m_c3p, m_c3pp;
    logic [1:0] mdl_mode_q;

    typedef struct {
        logic [1:0]  md;
        int          x;
        int          n;
        int          exp_sum;
        int          tol;
        int          lo;
        int          hi;
        bit          has_pat;
        logic [15:0] pat;
    } vec_t;
    vec_t vecs[7];

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_in(string name, int act, int lo, int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic fail_now(string name);
        n_checks++;
        $display("FAIL %s: bound expired or queue empty", name);
    endtask

    function automatic void mdl_clear();
        m_a1 = 0; m_a2 = 0; m_a3 = 0;
        m_c2p = 0; m_c3p = 0; m_c3pp = 0;
    endfunction

    // Integer reference of the cascade: carry = overflow past 2^16.
    function automatic int mdl_step(int x);
        int st, c1, y;
        int c2 = 0;
        int c3 = 0;
        st = (mdl_mode_q == 2'd0) ? 1 : int'(mdl_mode_q);
        m_a1 = m_a1 + x;
        c1 = m_a1 / 65536;
        m_a1 = m_a1 % 65536;
        if (st >= 2) begin
            m_a2 = m_a2 + m_a1;
            c2 = m_a2 / 65536;
            m_a2 = m_a2 % 65536;
        end
        if (st == 3) begin
            m_a3 = m_a3 + m_a2;
            c3 = m_a3 / 65536;
            m_a3 = m_a3 % 65536;
        end
        y = c1 + (c2 - m_c2p) + (c3 - 2 * m_c3p + m_c3pp);
        if (st >= 2) m_c2p = c2;
        if (st == 3) begin
            m_c3pp = m_c3p;
            m_c3p  = c3;
        end
        return y;
    endfunction

    function automatic void stat_reset();
        sum = 0; ymin = 1000; ymax = -1000; n_out = 0;
        outs.delete();
    endfunction

    // One clock: called at a falling edge with inputs set, returns at the next falling edge.
    task automatic step(output bit acc);
        int got, exp;
        #1;
        if (mode != mdl_mode_q) mdl_clear();
        if (m_tvalid && m_tready) begin
            got = int'($signed(m_tdata));
            if (sb.size() == 0) fail_now("sb_underflow");
            else begin
                exp = sb.pop_front();
                check("sb_out", got, exp);
                sum = sum + got;
                if (got < ymin) ymin = got;
                if (got > ymax) ymax = got;
                n_out++;
                if (outs.size() < 64) outs.push_back(got);
            end
        end
        acc = s_tvalid && s_tready;
        if (acc) sb.push_back(mdl_step(int'(s_tdata)));
        mdl_mode_q = mode;
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        arst_n = 1'b0;
        s_tvalid = 1'b0;
        @(negedge aclk);
        arst_n = 1'b1;
        mdl_clear();
        mdl_mode_q = 2'd0;
        sb.delete();
        stat_reset();
    endtask

    task automatic drain();
        bit a;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 8 && (sb.size() != 0 || m_tvalid); i++) step(a);
        if (sb.size() != 0) fail_now("drain");
    endtask

    task automatic run_stream(int n);
        bit a;
        int got_n = 0;
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        for (int i = 0; i < n + 20 && got_n < n; i++) begin
            step(a);
            if (a) got_n++;
        end
        if (got_n < n) fail_now("accept_count");
        drain();
    endtask

    initial begin
        bit a;
        int hd, zc;
        int outs_a[$];
        logic signed [3:0] code;

        vecs[0] = '{2'd1, 32'h4000, 64,   16,   0, 0,  1, 1'b1, 16'h0001};
        vecs[1] = '{2'd2, 32'h8000, 1024, 512,  0, -1, 2, 1'b1, 16'h0110};
        vecs[2] = '{2'd3, 32'hFFFF, 4096, 4095, 3, -3, 4, 1'b0, 16'h0000};
        vecs[3] = '{2'd0, 32'h4000, 64,   16,   0, 0,  1, 1'b1, 16'h0001};
        vecs[4] = '{2'd1, 32'hFFFF, 100,  99,   0, 0,  1, 1'b0, 16'h0000};
        vecs[5] = '{2'd3, 32'h1000, 512,  32,   3, -3, 4, 1'b0, 16'h0000};
        vecs[6] = '{2'd2, 32'h0000, 32,   0,    0, -1, 2, 1'b0, 16'h0000};

        arst_n = 1'b0; mode = 2'd0; s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b1;
        repeat (2) @(negedge aclk);
        #1;
        check("rst_tvalid", int'(m_tvalid), 0);
        check("rst_tdata", int'(m_tdata), 0);
        check("rst_tready", int'(s_tready), 0);

        // Vector table: constant input, scoreboard per code, then sum/range/pattern.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            mode = vecs[v].md;
            s_tdata = vecs[v].x[15:0];
            run_stream(vecs[v].n);
            check("out_count", n_out, vecs[v].n);
            check_in("sum", sum, vecs[v].exp_sum - vecs[v].tol, vecs[v].exp_sum + vecs[v].tol);
            check_in("min_code", ymin, vecs[v].lo, vecs[v].hi);
            check_in("max_code", ymax, vecs[v].lo, vecs[v].hi);
            if (vecs[v].has_pat) begin
                for (int i = 0; i < 16 && i < outs.size(); i++) begin
                    code = vecs[v].pat[(3 - (i % 4)) * 4 +: 4];
                    check("pattern", outs[i], int'(code));
                end
            end
        end

        // First code one cycle after first accept.
        do_reset();
        mode = 2'd1; s_tdata = 16'h4000; s_tvalid = 1'b1; m_tready = 1'b1;
        a = 1'b0;
        for (int i = 0; i < 5 && !a; i++) step(a);
        if (!a) fail_now("first_accept");
        else begin
            #1;
            check("lat_tvalid", int'(m_tvalid), 1);
            check("lat_tdata", int'(m_tdata), 0);
        end
        drain();

        // Asynchronous reset mid-stream while an output is held.
        do_reset();
        mode = 2'd2; s_tdata = 16'h8000; s_tvalid = 1'b1; m_tready = 1'b1;
        repeat (6) step(a);
        m_tready = 1'b0;
        step(a);
        #1;
        check("pre_rst_tvalid", int'(m_tvalid), 1);
        #2;
        arst_n = 1'b0;
        #1;
        check("async_tvalid", int'(m_tvalid), 0);
        check("async_tdata", int'(m_tdata), 0);
        check("async_tready", int'(s_tready), 0);
        sb.delete();
        mdl_clear();
        mdl_mode_q = 2'd0;
        @(negedge aclk);
        arst_n = 1'b1;
        m_tready = 1'b1;
        #1;
        check("release_tready", int'(s_tready), 0);
        step(a);
        step(a);
        #1;
        check("tready_after_2", int'(s_tready), 1);
        drain();

        // Backpressure: output held, input stalled, sequence unbroken.
        do_reset();
        stat_reset();
        mode = 2'd2; s_tdata = 16'h8000; s_tvalid = 1'b1; m_tready = 1'b1;
        repeat (10) step(a);
        m_tready = 1'b0;
        #1;
        hd = int'(m_tdata);
        check("bp_tvalid0", int'(m_tvalid), 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_tready", int'(s_tready), 0);
            step(a);
            #1;
            check("bp_tdata", int'(m_tdata), hd);
            check("bp_tvalid", int'(m_tvalid), 1);
        end
        m_tready = 1'b1;
        repeat (20) step(a);
        drain();
        for (int i = 0; i < outs.size(); i++) begin
            code = (i % 4 == 1 || i % 4 == 2) ? 4'sd1 : 4'sd0;
            check("bp_pattern", outs[i], int'(code));
        end

        // Mode switch 3 -> 2 mid-stream, compared with a fresh mode 2 run.
        do_reset();
        mode = 2'd3; s_tdata = 16'h6000; s_tvalid = 1'b1; m_tready = 1'b1;
        repeat (12) step(a);
        mode = 2'd2;
        zc = 0;
        #1;
        if (!s_tready) zc++;
        step(a);
        outs.delete();
        for (int i = 0; i < 3; i++) begin
            #1;
            if (!s_tready) zc++;
            step(a);
        end
        check("switch_stall_cycles", zc, 1);
        repeat (20) step(a);
        drain();
        outs_a = outs;
        do_reset();
        mode = 2'd2; s_tdata = 16'h6000;
        run_stream(24);
        check_in("switch_len", outs_a.size(), 16, 64);
        for (int i = 0; i < outs_a.size() && i < outs.size(); i++)
            check("switch_vs_fresh", outs_a[i], outs[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
